mult_div_sequencer: RTL and testbench
=====================================

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

Interface
REQ-001 Parameter: DATA_W, default 32, operand width; the design is specified and verified at 32 only.
REQ-002 Parameter: ITERS, default 32, number of iteration cycles; SHALL equal DATA_W.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request from uControl; sampled only in IDLE.
REQ-006 MDCtrl  in  1  operation select: 0 = signed multiply, 1 = signed divide.
REQ-007 srcA  in  DATA_W  operand A: multiplicand or dividend (rs).
REQ-008 srcB  in  DATA_W  operand B: multiplier or divisor (rt).
REQ-009 busy  out  1  high while an operation is in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 div0  out  1  one-cycle pulse, coincident with done, flagging a divide by zero.
REQ-012 HILOWrite  out  1  one-cycle pulse, coincident with done, when hi/lo were updated.
REQ-013 hi  out  DATA_W  HI register: product upper word, or remainder.
REQ-014 lo  out  DATA_W  LO register: product lower word, or quotient.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIN and Z0.
REQ-016 IDLE with start=1 and (MDCtrl=0 or srcB!=0): latch operand magnitudes, result signs and MDCtrl; clear the iteration counter; next state RUN.
REQ-017 IDLE with start=1, MDCtrl=1 and srcB==0: next state Z0.
REQ-018 Z0 lasts exactly one cycle: done=1, div0=1, HILOWrite=0, hi/lo unchanged; next state IDLE.
REQ-019 RUN: one radix-2 step per cycle (multiply: shift-add; divide: restoring shift-subtract); counter increments 0..ITERS-1; at count ITERS-1, next state FIN.
REQ-020 FIN: apply two's-complement sign correction and register hi/lo; next state IDLE.
REQ-021 done and HILOWrite SHALL be high for exactly the one cycle after FIN, with hi/lo already valid in that cycle.
REQ-022 Latency: start sampled at edge k; done high from edge k+ITERS+1 to edge k+ITERS+2 (33 cycles at default).
REQ-023 busy SHALL be high in RUN and FIN only; it is low in IDLE and Z0, and low while done is high.
REQ-024 start while not in IDLE SHALL be ignored, with no queuing; operand changes after the latch edge SHALL have no effect.
REQ-025 Multiply: {hi,lo} = 64-bit signed product of srcA and srcB.
REQ-026 Divide: lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
REQ-027 Divide with srcA=0x80000000 and srcB=0xFFFFFFFF SHALL produce lo=0x80000000, hi=0, with no flag.
REQ-028 hi/lo SHALL change only at the FIN edge or on reset.

Reset
REQ-029 reset low SHALL immediately force: state IDLE, counter 0, busy=0, done=0, div0=0, HILOWrite=0, hi=0, lo=0.
REQ-030 Reset mid-operation SHALL abort the operation; no done pulse follows, and the next start SHALL behave as the first start after reset.
REQ-031 Deassertion of reset SHALL take effect at the next rising clk edge; start sampled at that edge SHALL be honoured.

Structure
REQ-032 Shared package mult_div_pkg SHALL hold the FSM state type (IDLE/RUN/FIN/Z0), DATA_W/ITERS defaults, and the MDCtrl encodings MD_MULT=0 and MD_DIV=1.
REQ-033 One sub-module, md_step, SHALL be combinational: one iteration (add-or-subtract and shift) on the {remainder/upper, quotient/lower} pair; the sequencer owns all registers.
REQ-034 Sign handling (absolute value on entry, negation in FIN) SHALL live in the sequencer, not in md_step.

Verification
REQ-035 Multiply srcA=7, srcB=-3 (0xFFFFFFFD) -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; HILOWrite=1 and div0=0 in the same cycle.
REQ-036 Divide srcA=-7, srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divide srcA=0x80000000, srcB=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Preload hi=0x12345678 via a multiply, then divide by srcB=0 -> done and div0 high one cycle after start, HILOWrite=0, busy never high, hi still 0x12345678.
REQ-038 Second start asserted 5 cycles into a multiply -> ignored: a single done at cycle 33, result from the first operands only.
REQ-039 Reset asserted at cycle 10 of a divide -> all outputs 0 at once, no done pulse; a new multiply 0x10000 * 0x10000 -> hi=1, lo=0, completed 33 cycles after its start.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer:
// FSM state encoding, width defaults and MDCtrl operation encodings.
package mult_div_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ITERS_DEF  = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    Z0   = 2'd3
  } state_t;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module md_step
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_md,
  input  logic [DATA_W-1:0] i_upper,
  input  logic [DATA_W-1:0] i_lower,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_upper,
  output logic [DATA_W-1:0] o_lower
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W-1:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_operand} : '0);
    w_shl   = {i_upper, i_lower[DATA_W-1]};
    // Only taken when w_shl >= operand, so the result is below the divisor
    // and the truncated subtraction is exact.
    w_diff  = w_shl[DATA_W-1:0] - i_operand;
    o_upper = w_sum[DATA_W:1];
    o_lower = {w_sum[0], i_lower[DATA_W-1:1]};
    if (i_md == MD_DIV) begin
      if (w_shl >= {1'b0, i_operand}) begin
        o_upper = w_diff;
        o_lower = {i_lower[DATA_W-2:0], 1'b1};
      end else begin
        o_upper = w_shl[DATA_W-1:0];
        o_lower = {i_lower[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide unit: sign-magnitude conversion on entry,
// ITERS radix-2 steps through md_step, sign correction into HI/LO at FIN.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ITERS  = ITERS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              MDCtrl,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic              HILOWrite,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_md;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DATA_W-1:0]   r_upper;
  logic [DATA_W-1:0]   r_lower;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;
  logic                r_div0;
  logic                r_hw;

  logic                w_load;
  logic                w_zero;
  logic                w_fin;
  logic [DATA_W-1:0]   w_step_upper;
  logic [DATA_W-1:0]   w_step_lower;
  logic [2*DATA_W-1:0] w_prod;

  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] f_cneg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? -v : v;
  endfunction

  md_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_md      (r_md),
    .i_upper   (r_upper),
    .i_lower   (r_lower),
    .i_operand (r_operand),
    .o_upper   (w_step_upper),
    .o_lower   (w_step_lower)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_zero = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((MDCtrl == MD_DIV) && (srcB == '0)) begin
            w_zero = 1'b1;
            w_next = Z0;
          end else begin
            w_load = 1'b1;
            w_next = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      Z0:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_hw    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fin | w_zero;
      r_div0  <= w_zero;
      r_hw    <= w_fin;
      if (w_load) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fin) begin
        if (r_md == MD_MULT) begin
          {r_hi, r_lo} <= r_neg_q ? -w_prod : w_prod;
        end else begin
          r_lo <= f_cneg(r_neg_q, r_lower);
          r_hi <= f_cneg(r_neg_r, r_upper);
        end
      end
    end
  end

  // Working datapath: reloaded on every accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_md    <= MDCtrl;
      r_neg_q <= srcA[DATA_W-1] ^ srcB[DATA_W-1];
      r_neg_r <= srcA[DATA_W-1];
      r_upper <= '0;
      if (MDCtrl == MD_MULT) begin
        r_operand <= f_abs(srcA);
        r_lower   <= f_abs(srcB);
      end else begin
        r_operand <= f_abs(srcB);
        r_lower   <= f_abs(srcA);
      end
    end else if (r_state == RUN) begin
      r_upper <= w_step_upper;
      r_lower <= w_step_lower;
    end
  end

  assign w_prod    = {r_upper, r_lower};
  assign busy      = (r_state == RUN) || (r_state == FIN);
  assign done      = r_done;
  assign div0      = r_div0;
  assign HILOWrite = r_hw;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: reference results from native
// 64-bit arithmetic are queued at start and compared when done pulses.
module tb_mult_div_sequencer;
  import mult_div_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        MDCtrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic        div0;
  logic        HILOWrite;
  logic [31:0] hi;
  logic [31:0] lo;

  int   n_checks;
  int   n_errors;
  res_t sb[$];

  mult_div_sequencer #(
    .DATA_W (32),
    .ITERS  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDCtrl    (MDCtrl),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .HILOWrite (HILOWrite),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic md, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, p, q, r;
    res_t   res;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (md == MD_MULT) begin
      p      = la * lb;
      res.hi = p[63:32];
      res.lo = p[31:0];
    end else begin
      q      = la / lb;
      r      = la % lb;
      res.hi = r[31:0];
      res.lo = q[31:0];
    end
    return res;
  endfunction

  // Present a request for one clock edge, then scramble the operand inputs.
  task automatic do_start(input logic md, input logic [31:0] a, input logic [31:0] b);
    MDCtrl = md;
    srcA   = a;
    srcB   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    srcA   = $urandom;
    srcB   = $urandom;
    MDCtrl = 1'($urandom_range(0, 1));
  endtask

  // Returns edges elapsed until done (budget+1 on timeout) and how many
  // pre-done cycles showed busy low.
  task automatic wait_done(input int budget, output int cyc, output int busy_bad);
    cyc      = budget + 1;
    busy_bad = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = n;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    MDCtrl = 1'b0;
    srcA = '0;
    srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (div0 !== 1'b0) begin n_errors++; $display("FAIL reset_div0 got=%b want=0", div0); end
    n_checks++; if (HILOWrite !== 1'b0) begin n_errors++; $display("FAIL reset_hilowrite got=%b want=0", HILOWrite); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi got=%h want=00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo got=%h want=00000000", lo); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult_basic();
    int   cyc, bb;
    res_t exp;
    sb.push_back(model(MD_MULT, 32'd7, 32'hFFFF_FFFD));
    do_start(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mult_busy_start got=%b want=1", busy); end
    wait_done(40, cyc, bb);
    exp = sb.pop_front();
    n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL mult_latency got=%0d want=33", cyc); end
    n_checks++; if (bb !== 0) begin n_errors++; $display("FAIL mult_busy_run got=%0d low cycles want=0", bb); end
    n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL mult_sb got=%h_%h want=%h_%h", hi, lo, exp.hi, exp.lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
    n_checks++; if (HILOWrite !== 1'b1) begin n_errors++; $display("FAIL mult_hilowrite got=%b want=1", HILOWrite); end
    n_checks++; if (div0 !== 1'b0) begin n_errors++; $display("FAIL mult_div0 got=%b want=0", div0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mult_busy_done got=%b want=0", busy); end
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mult_done_width got=%b want=0", done); end
    n_checks++; if (HILOWrite !== 1'b0) begin n_errors++; $display("FAIL mult_hw_width got=%b want=0", HILOWrite); end
  endtask

  // Operations issued back to back: each start lands in the done cycle.
  task automatic test_ops(input logic md, input logic [31:0] ta[8], input logic [31:0] tb[8]);
    int   cyc, bb;
    res_t exp;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(model(md, ta[i], tb[i]));
      do_start(md, ta[i], tb[i]);
      wait_done(40, cyc, bb);
      exp = sb.pop_front();
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL op%0d_latency md=%b got=%0d want=33", i, md, cyc); end
      n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL op%0d_result md=%b a=%h b=%h got=%h_%h want=%h_%h", i, md, ta[i], tb[i], hi, lo, exp.hi, exp.lo); end
      n_checks++; if ({HILOWrite, div0, bb} !== {1'b1, 1'b0, 32'd0}) begin n_errors++; $display("FAIL op%0d_flags got hw=%b div0=%b busylow=%0d want hw=1 div0=0 busylow=0", i, HILOWrite, div0, bb); end
      if (md == MD_DIV && ta[i] == 32'hFFFF_FFF9 && tb[i] == 32'd2) begin
        n_checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_errors++; $display("FAIL div_m7_2 got=%h_%h want=ffffffff_fffffffd", hi, lo); end
      end
      if (md == MD_DIV && ta[i] == 32'h8000_0000 && tb[i] == 32'hFFFF_FFFF) begin
        n_checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin n_errors++; $display("FAIL div_overflow got=%h_%h want=00000000_80000000", hi, lo); end
      end
    end
  endtask

  task automatic test_div0();
    int   cyc, bb;
    res_t exp;
    sb.push_back(model(MD_MULT, 32'hDB97_5310, 32'h8000_0000));
    do_start(MD_MULT, 32'hDB97_5310, 32'h8000_0000);
    wait_done(40, cyc, bb);
    exp = sb.pop_front();
    n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL preload got=%h_%h want=%h_%h", hi, lo, exp.hi, exp.lo); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL preload_hi got=%h want=12345678", hi); end
    do_start(MD_DIV, 32'd99, 32'd0);
    n_checks++; if ({done, div0, HILOWrite, busy} !== 4'b1100) begin n_errors++; $display("FAIL div0_pulse got done=%b div0=%b hw=%b busy=%b want 1 1 0 0", done, div0, HILOWrite, busy); end
    n_checks++; if ({hi, lo} !== {32'h1234_5678, 32'h0}) begin n_errors++; $display("FAIL div0_hilo got=%h_%h want=12345678_00000000", hi, lo); end
    @(posedge clk);
    #1;
    n_checks++; if ({done, div0, busy} !== 3'b000) begin n_errors++; $display("FAIL div0_after got done=%b div0=%b busy=%b want 0 0 0", done, div0, busy); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL div0_hi_kept got=%h want=12345678", hi); end
  endtask

  task automatic test_ignore_start();
    int   cyc, bb, extra;
    res_t exp;
    sb.push_back(model(MD_MULT, 32'h0001_2345, 32'hFFFF_0F00));
    do_start(MD_MULT, 32'h0001_2345, 32'hFFFF_0F00);
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    MDCtrl = MD_DIV;
    srcA   = 32'h5555_5555;
    srcB   = 32'd3;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done(40, cyc, bb);
    exp = sb.pop_front();
    n_checks++; if (cyc + 5 !== 33) begin n_errors++; $display("FAIL ignore_latency got=%0d want=33", cyc + 5); end
    n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL ignore_result got=%h_%h want=%h_%h", hi, lo, exp.hi, exp.lo); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL ignore_queued got=%0d active cycles want=0", extra); end
  endtask

  task automatic test_reset_abort();
    int   cyc, bb;
    res_t exp;
    do_start(MD_DIV, 32'hFFFF_FC18, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if ({busy, done, div0, HILOWrite} !== 4'b0000) begin n_errors++; $display("FAIL abort_ctrl got busy=%b done=%b div0=%b hw=%b want 0000", busy, done, div0, HILOWrite); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_errors++; $display("FAIL abort_hilo got=%h_%h want=0_0", hi, lo); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abort_no_done got=%b want=0", done); end
    sb.push_back(model(MD_MULT, 32'h0001_0000, 32'h0001_0000));
    reset = 1'b1;
    do_start(MD_MULT, 32'h0001_0000, 32'h0001_0000);
    wait_done(40, cyc, bb);
    exp = sb.pop_front();
    n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL abort_restart_latency got=%0d want=33", cyc); end
    n_checks++; if ({hi, lo} !== {32'h1, 32'h0}) begin n_errors++; $display("FAIL abort_restart got=%h_%h want=00000001_00000000", hi, lo); end
    n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL abort_restart_sb got=%h_%h want=%h_%h", hi, lo, exp.hi, exp.lo); end
  endtask

  initial begin
    logic [31:0] ma[8], mb[8], da[8], db[8];
    n_checks = 0;
    n_errors = 0;
    ma = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd12345, 32'h0, 32'h0};
    mb = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FF85, 32'h0, 32'h0};
    da = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'h0, 32'h7FFF_FFFF};
    db = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'd5, 32'h8000_0000};
    for (int i = 6; i < 8; i++) begin
      ma[i] = $urandom;
      mb[i] = $urandom;
    end
    test_reset();
    test_mult_basic();
    test_ops(MD_MULT, ma, mb);
    test_ops(MD_DIV, da, db);
    test_div0();
    test_ignore_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
